// File: rtl/mp_adder_seq.sv
// Multi-precision add/subtract sequencer. One WIDTH-bit adder slice is swept
// across the operand words, least significant word first, one word per clock.
module mp_adder_seq #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sub,
  input  logic [WORDS*WIDTH-1:0] a,
  input  logic [WORDS*WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDS*WIDTH-1:0] y,
  output logic                   cout,
  output logic                   ovf
);

  localparam int N  = WORDS * WIDTH;
  localparam int IW = (WORDS > 2) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    y_q;
  logic            cout_q;
  logic            ovf_q;
  logic            in_ready_q;
  logic            out_valid_q;

  logic [WIDTH-1:0] aWord;
  logic [WIDTH-1:0] bWord;
  logic [WIDTH-1:0] sWord;
  logic             cWord;
  logic             lastWord;

  // The single shared slice; B already holds ~b for subtraction.
  always_comb begin
    aWord           = a_q[idx_q*WIDTH +: WIDTH];
    bWord           = b_q[idx_q*WIDTH +: WIDTH];
    {cWord, sWord}  = {1'b0, aWord} + {1'b0, bWord} + {{WIDTH{1'b0}}, carry_q};
    lastWord        = (idx_q == IW'(WORDS - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      y_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            carry_q    <= sub;
            y_q        <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          y_q[idx_q*WIDTH +: WIDTH] <= sWord;
          carry_q                   <= cWord;
          idx_q                     <= idx_q + IW'(1);
          // Overflow uses the post-inversion B msb, so one rule covers add and sub.
          if (lastWord) begin
            cout_q      <= cWord;
            ovf_q       <= (aWord[WIDTH-1] == bWord[WIDTH-1]) &&
                           (sWord[WIDTH-1] != aWord[WIDTH-1]);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
